// File: rtl/kf6845_pkg.sv
// Shared widths, register bundle and sync-pulse state
// for the kf6845 horizontal and vertical stages.
package kf6845_pkg;

  localparam int CHAR_W = 8;
  localparam int SYNC_W = 4;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [SYNC_W-1:0] swidth_t;

  typedef enum logic {
    IDLE = 1'b0,
    SYNC = 1'b1
  } sync_state_t;

  typedef struct packed {
    char_t r0;
    char_t r1;
    char_t r2;
    char_t r3;
  } hregs_t;

endpackage

// File: rtl/kf6845_sync_pulse.sv
// Width-counted sync pulse generator; shared by HSYNC and VSYNC.
// Width is compared live, so a rewrite mid-pulse takes effect at once.
module kf6845_sync_pulse
  import kf6845_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    i_enable,
  input  logic    i_trigger,
  input  swidth_t i_width,
  output logic    o_sync
);

  sync_state_t r_state;
  sync_state_t w_state_nxt;
  swidth_t     r_wcnt;
  swidth_t     w_wcnt_nxt;
  logic        r_sync;
  logic        w_sync_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_sync  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_sync  <= w_sync_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_sync_nxt  = r_sync;
    if (i_enable) begin
      unique case (r_state)
        IDLE: begin
          if (i_trigger && (i_width != '0)) begin
            w_state_nxt = SYNC;
            w_wcnt_nxt  = 4'd1;
            w_sync_nxt  = 1'b1;
          end
        end
        SYNC: begin
          // Trigger is ignored here: no retrigger while active
          if (r_wcnt == i_width) begin
            w_state_nxt = IDLE;
            w_sync_nxt  = 1'b0;
          end else begin
            w_wcnt_nxt = r_wcnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_sync_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/kf6845_horizontal_control.sv
// CRTC horizontal stage: R0-R3, character counter,
// line/half-line strobes, display window and HSYNC.
module kf6845_horizontal_control
  import kf6845_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              video_clock_enable,
  input  logic [CHAR_W-1:0] internal_data_bus,
  input  logic              write_horizontal_total_register,
  input  logic              write_horizontal_displayed_register,
  input  logic              write_horizontal_sync_position_register,
  input  logic              write_sync_width_register,
  output logic              Horizontal,
  output logic              Horizontal_Half,
  output logic              H_Display,
  output logic              HSYNC,
  output logic [CHAR_W-1:0] Character_Count,
  output logic [SYNC_W-1:0] VSYNC_Width
);

  hregs_t r_regs;
  char_t  r_count;
  logic   w_eol;
  logic   w_half;
  logic   w_sync_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
    end else begin
      if (write_horizontal_total_register)
        r_regs.r0 <= internal_data_bus;
      if (write_horizontal_displayed_register)
        r_regs.r1 <= internal_data_bus;
      if (write_horizontal_sync_position_register)
        r_regs.r2 <= internal_data_bus;
      if (write_sync_width_register)
        r_regs.r3 <= internal_data_bus;
    end
  end

  assign w_eol      = (r_count == r_regs.r0);
  assign w_half     = (r_count == {1'b0, r_regs.r0[CHAR_W-1:1]});
  assign w_sync_hit = (r_count == r_regs.r2);

  // Counter past a lowered R0 simply wraps modulo 256
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (video_clock_enable) begin
      r_count <= w_eol ? '0 : r_count + 8'd1;
    end
  end

  kf6845_sync_pulse u_hsync (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_enable  (video_clock_enable),
    .i_trigger (w_sync_hit),
    .i_width   (r_regs.r3[SYNC_W-1:0]),
    .o_sync    (HSYNC)
  );

  assign Horizontal      = w_eol & video_clock_enable;
  assign Horizontal_Half = w_half & video_clock_enable;
  assign H_Display       = (r_count < r_regs.r1);
  assign Character_Count = r_count;
  assign VSYNC_Width     = r_regs.r3[CHAR_W-1:SYNC_W];

endmodule
